// File: rtl/cover_toggle_pkg.sv
// Shared types and helpers for the toggle-coverage scheduler.
package cover_toggle_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;

  localparam int IDX_W_DEFAULT = 64;
  localparam int MAX_WIDTH     = 1024;

  function automatic int unsigned popcount(input logic [MAX_WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_WIDTH; i++) n += 32'(v[i]);
    return n;
  endfunction

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/cover_toggle_pe.sv
// Lowest-set-bit priority encoder; purely combinational.
module cover_toggle_pe
  import cover_toggle_pkg::*;
#(
  parameter int WIDTH = 62,
  parameter int IW    = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/cover_toggle_sched.sv
// Toggle-coverage group scheduler: sticky first-hit map serialised into a
// valid/ready stream of global cover indices, lowest bit first.
module cover_toggle_sched
  import cover_toggle_pkg::*;
#(
  parameter int WIDTH       = 62,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8940,
  parameter int IDX_W       = IDX_W_DEFAULT
) (
  input  logic                         gbl_clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_index,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         all_hit,
  output logic                         busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PE_W  = (WIDTH > 1) ? clog2(WIDTH) : 1;

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_params
    $error("cover_toggle_sched: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   seen_q, seen_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   out_index_q, out_index_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;

  logic [WIDTH-1:0]   new_hits;
  logic [WIDTH-1:0]   pend_avail;
  logic               slot_free;
  logic [PE_W-1:0]    pe_idx;
  logic               pe_any;

  // Clear discards this cycle's hits and hides pending bits from the slot.
  assign new_hits   = (state_q == ARMED && !clear) ? (valid & ~seen_q) : '0;
  assign pend_avail = clear ? '0 : pend_q;
  assign slot_free  = !out_valid_q || out_ready;

  cover_toggle_pe #(
    .WIDTH (WIDTH),
    .IW    (PE_W)
  ) u_pe (
    .req (pend_avail),
    .idx (pe_idx),
    .any (pe_any)
  );

  // Bits captured this cycle join pend after the load, so they wait one cycle.
  always_comb begin
    seen_d      = clear ? '0 : (seen_q | new_hits);
    hit_count_d = clear ? '0 : hit_count_q + CNT_W'(popcount(MAX_WIDTH'(new_hits)));
    pend_d      = pend_avail;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    if (slot_free) begin
      out_valid_d = pe_any;
      if (pe_any) begin
        out_index_d    = IDX_W'(COVER_INDEX) + IDX_W'(pe_idx);
        pend_d[pe_idx] = 1'b0;
      end
    end
    pend_d = pend_d | new_hits;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (en) state_d = ARMED;
      ARMED: if (!en) state_d = (pend_avail != '0 || new_hits != '0 || out_valid_q) ? DRAIN : IDLE;
      DRAIN: begin
        if (en) state_d = ARMED;
        else if (pend_avail == '0 && slot_free) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      seen_q      <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign hit_count = hit_count_q;
  assign all_hit   = (hit_count_q == CNT_W'(WIDTH));
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Scenario tasks plus a randomized run against a bit-set reference model.
module tb_cover_toggle_sched;

  localparam int WIDTH       = 62;
  localparam int COVER_INDEX = 100;
  localparam int COVER_TOTAL = 8940;
  localparam int IDX_W       = 64;
  localparam int CNT_W       = $clog2(WIDTH + 1);

  logic              gbl_clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  valid = '0;
  logic              out_valid;
  logic [IDX_W-1:0]  out_index;
  logic [CNT_W-1:0]  hit_count;
  logic              all_hit;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sets of seen/pending bits and a single presentation slot.
  logic [WIDTH-1:0]  m_seen, m_pend;
  logic              m_ov, m_armed;
  logic [IDX_W-1:0]  m_idx;
  int                m_cnt;
  logic [IDX_W-1:0]  got_q[$];

  cover_toggle_sched #(
    .WIDTH(WIDTH), .COVER_INDEX(COVER_INDEX), .COVER_TOTAL(COVER_TOTAL), .IDX_W(IDX_W)
  ) dut (
    .gbl_clk(gbl_clk), .reset(reset), .en(en), .clear(clear), .valid(valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .hit_count(hit_count), .all_hit(all_hit), .busy(busy)
  );

  always #5 gbl_clk = ~gbl_clk;

  // Advance one clock: log accepted indices, step the model, settle after the edge.
  task automatic tick();
    logic [WIDTH-1:0] newb, avail;
    int b;
    if (out_valid && out_ready) got_q.push_back(out_index);
    if (!reset) begin
      m_seen = '0; m_pend = '0; m_ov = 1'b0; m_idx = '0; m_cnt = 0; m_armed = 1'b0;
    end else begin
      newb  = (m_armed && !clear) ? (valid & ~m_seen) : '0;
      avail = clear ? '0 : m_pend;
      if (!m_ov || out_ready) begin
        b = -1;
        for (int i = 0; i < WIDTH; i++) if (avail[i] && b < 0) b = i;
        if (b >= 0) begin
          m_ov = 1'b1; m_idx = IDX_W'(COVER_INDEX + b); avail[b] = 1'b0;
        end else m_ov = 1'b0;
      end
      m_pend  = avail | newb;
      m_seen  = clear ? '0 : (m_seen | newb);
      m_cnt   = clear ? 0 : m_cnt + $countones(newb);
      m_armed = en;
    end
    @(posedge gbl_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; clear = 1'b0; valid = '1; out_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || out_index !== '0 || hit_count !== '0 || all_hit !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%0b i=%0d n=%0d a=%0b b=%0b, want all zero",
               out_valid, out_index, hit_count, all_hit, busy);
    end
    valid = '0; reset = 1'b1;
    tick();
  endtask

  task automatic test_single_hit();
    en = 1'b1; out_ready = 1'b1;
    tick();
    valid = WIDTH'(1) << 5; tick(); valid = '0;
    vectors++;
    if (out_valid !== 1'b0 || hit_count !== CNT_W'(1)) begin
      miscompares++;
      $display("[TB] FAIL single_e0: got v=%0b n=%0d, want v=0 n=1", out_valid, hit_count);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_index !== IDX_W'(105)) begin
      miscompares++;
      $display("[TB] FAIL single_e1: got v=%0b i=%0d, want v=1 i=105", out_valid, out_index);
    end
    tick();
    valid = WIDTH'(1) << 5; tick(); valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || hit_count !== CNT_W'(1)) begin
        miscompares++;
        $display("[TB] FAIL single_repeat: got v=%0b n=%0d, want v=0 n=1", out_valid, hit_count);
      end
    end
  endtask

  task automatic test_burst();
    int exp_idx[3] = '{100, 130, 161};
    clear = 1'b1; tick(); clear = 1'b0;
    valid = (WIDTH'(1) << 61) | (WIDTH'(1) << 0) | (WIDTH'(1) << 30);
    tick(); valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_index !== IDX_W'(exp_idx[k])) begin
        miscompares++;
        $display("[TB] FAIL burst_order[%0d]: got v=%0b i=%0d, want v=1 i=%0d", k, out_valid, out_index, exp_idx[k]);
      end
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || hit_count !== CNT_W'(3)) begin
      miscompares++;
      $display("[TB] FAIL burst_end: got v=%0b n=%0d, want v=0 n=3", out_valid, hit_count);
    end
  endtask

  task automatic test_backpressure();
    int exp_idx[3] = '{100, 103, 109};
    clear = 1'b1; tick(); clear = 1'b0;
    out_ready = 1'b0;
    valid = (WIDTH'(1) << 0) | (WIDTH'(1) << 3) | (WIDTH'(1) << 9);
    tick(); valid = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_index !== IDX_W'(100)) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold[%0d]: got v=%0b i=%0d, want v=1 i=100", k, out_valid, out_index);
      end
    end
    out_ready = 1'b1; got_q.delete();
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (out_valid !== m_ov || (m_ov && out_index !== m_idx)) begin
        miscompares++;
        $display("[TB] FAIL backpressure_step[%0d]: got v=%0b i=%0d, want v=%0b i=%0d", k, out_valid, out_index, m_ov, m_idx);
      end
    end
    vectors++;
    if (got_q.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL backpressure_count: got %0d, want 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got_q[k] !== IDX_W'(exp_idx[k])) begin
          miscompares++;
          $display("[TB] FAIL backpressure_seq[%0d]: got %0d, want %0d", k, got_q[k], exp_idx[k]);
        end
      end
    end
  endtask

  task automatic test_full_coverage();
    clear = 1'b1; tick(); clear = 1'b0;
    vectors++;
    if (all_hit !== 1'b0 || hit_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL full_pre: got a=%0b n=%0d, want a=0 n=0", all_hit, hit_count);
    end
    valid = '1; got_q.delete(); tick(); valid = '0;
    vectors++;
    if (all_hit !== 1'b1 || hit_count !== CNT_W'(62)) begin
      miscompares++;
      $display("[TB] FAIL full_all_hit: got a=%0b n=%0d, want a=1 n=62", all_hit, hit_count);
    end
    for (int c = 0; c < 66; c++) begin
      tick();
      vectors++;
      if (out_valid !== m_ov || (m_ov && out_index !== m_idx)) begin
        miscompares++;
        $display("[TB] FAIL full_step[%0d]: got v=%0b i=%0d, want v=%0b i=%0d", c, out_valid, out_index, m_ov, m_idx);
      end
    end
    vectors++;
    if (got_q.size() != 62) begin
      miscompares++;
      $display("[TB] FAIL full_count: got %0d, want 62", got_q.size());
    end else begin
      for (int k = 0; k < 62; k++) begin
        vectors++;
        if (got_q[k] !== IDX_W'(100 + k)) begin
          miscompares++;
          $display("[TB] FAIL full_seq[%0d]: got %0d, want %0d", k, got_q[k], 100 + k);
        end
      end
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; tick();
    valid = WIDTH'(1) << 7; tick(); clear = 1'b0; valid = '0;
    vectors++;
    if (hit_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL clear_count: got %0d, want 0", hit_count);
    end
    got_q.delete();
    repeat (4) tick();
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL clear_no_emit: got %0d indices, want 0", got_q.size());
    end
    valid = WIDTH'(1) << 7; tick(); valid = '0;
    repeat (3) tick();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== IDX_W'(107)) begin
      miscompares++;
      $display("[TB] FAIL clear_rehit: got %0d indices first=%0d, want 1 index 107",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
    end
  endtask

  task automatic test_drain();
    int exp_idx[3] = '{102, 104, 106};
    clear = 1'b1; tick(); clear = 1'b0;
    out_ready = 1'b0;
    valid = (WIDTH'(1) << 2) | (WIDTH'(1) << 4) | (WIDTH'(1) << 6);
    tick(); valid = '0; en = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL drain_entry: got b=%0b v=%0b, want b=1 v=1", busy, out_valid);
    end
    out_ready = 1'b1; got_q.delete();
    repeat (5) tick();
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || got_q.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL drain_exit: got b=%0b v=%0b n=%0d, want b=0 v=0 n=3", busy, out_valid, got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got_q[k] !== IDX_W'(exp_idx[k])) begin
          miscompares++;
          $display("[TB] FAIL drain_seq[%0d]: got %0d, want %0d", k, got_q[k], exp_idx[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    en = 1'b1; tick();
    out_ready = 1'b0;
    valid = (WIDTH'(1) << 10) | (WIDTH'(1) << 11) | (WIDTH'(1) << 12);
    tick(); valid = '0; en = 1'b0;
    tick();
    reset = 1'b0; tick(); reset = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || hit_count !== '0 || busy !== 1'b0 || out_index !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_drain: got v=%0b n=%0d b=%0b i=%0d, want all zero",
               out_valid, hit_count, busy, out_index);
    end
    out_ready = 1'b1; valid = WIDTH'(1) << 20;
    repeat (3) tick();
    valid = '0;
    vectors++;
    if (out_valid !== 1'b0 || hit_count !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_ignores_valid: got v=%0b n=%0d b=%0b, want all zero", out_valid, hit_count, busy);
    end
  endtask

  task automatic test_random();
    logic [63:0] r1, r2, r3;
    en = 1'b1; tick();
    for (int c = 0; c < 500; c++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      r3 = {$urandom(), $urandom()};
      valid     = WIDTH'(r1 & r2 & r3);
      en        = ($urandom_range(0, 11) != 0);
      clear     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 149) != 0);
      tick();
      vectors++;
      if (out_valid !== m_ov || (m_ov && out_index !== m_idx) ||
          hit_count !== CNT_W'(m_cnt) || all_hit !== (m_cnt == WIDTH)) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: got v=%0b i=%0d n=%0d a=%0b, want v=%0b i=%0d n=%0d",
                 c, out_valid, out_index, hit_count, all_hit, m_ov, m_idx, m_cnt);
      end
    end
    reset = 1'b1; clear = 1'b0; valid = '0; en = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_burst();
    test_backpressure();
    test_full_coverage();
    test_clear();
    test_drain();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
